// File: rtl/stack_controller.sv
// Multi-cycle Moore control unit for the 8-bit stack processor: sequences fetch,
// decode, stack access, ALU and write-back, and drives every datapath enable.
module stack_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   output logic       PCWrite,
   output logic       PCJZ,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       DataSelect,
   output logic       push,
   output logic       pop,
   output logic       tos,
   output logic       AWrite,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       PCSrc,
   output logic [1:0] ALUControl,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IF    = 4'd0,
      S_ID    = 4'd1,
      S_TOS1  = 4'd2,
      S_LDA   = 4'd3,
      S_TOS2  = 4'd4,
      S_EXEC  = 4'd5,
      S_WB    = 4'd6,
      S_MEMRD = 4'd7,
      S_PUSHM = 4'd8,
      S_STORE = 4'd9,
      S_JMP   = 4'd10,
      S_JZ    = 4'd11
   } state_t;

   state_t cur;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= S_IF;
      end else begin
         case (cur)
            S_IF:    cur <= S_ID;
            S_ID: begin
               case (opcode)
                  3'b100:  cur <= S_MEMRD;
                  3'b110:  cur <= S_JMP;
                  default: cur <= S_TOS1;
               endcase
            end
            S_TOS1: begin
               case (opcode)
                  3'b101:  cur <= S_STORE;
                  3'b111:  cur <= S_JZ;
                  default: cur <= S_LDA;
               endcase
            end
            S_LDA:   cur <= (opcode == 3'b011) ? S_EXEC : S_TOS2;
            S_TOS2:  cur <= S_EXEC;
            S_EXEC:  cur <= S_WB;
            S_WB:    cur <= S_IF;
            S_MEMRD: cur <= S_PUSHM;
            S_PUSHM: cur <= S_IF;
            S_STORE: cur <= S_IF;
            S_JMP:   cur <= S_IF;
            S_JZ:    cur <= S_IF;
            default: cur <= S_IF;
         endcase
      end
   end

   // Decode is gated by rst so that enables drop the moment reset is asserted,
   // without waiting for a clock edge.
   always_comb begin
      PCWrite    = 1'b0;
      PCJZ       = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      DataSelect = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      tos        = 1'b0;
      AWrite     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 1'b0;
      PCSrc      = 1'b0;
      ALUControl = 2'b00;
      if (!rst) begin
         case (cur)
            S_IF: begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
            end
            S_TOS1, S_TOS2: tos = 1'b1;
            S_LDA: begin
               AWrite = 1'b1;
               pop    = 1'b1;
            end
            S_EXEC: begin
               ALUSrcA    = 1'b1;
               ALUControl = opcode[1:0];
               ALUSrcB    = (opcode[1:0] != 2'b11);
               pop        = (opcode[1:0] != 2'b11);
            end
            S_WB:    push = 1'b1;
            S_MEMRD: AdrSrc = 1'b1;
            S_PUSHM: begin
               push       = 1'b1;
               DataSelect = 1'b1;
            end
            S_STORE: begin
               AdrSrc   = 1'b1;
               MemWrite = 1'b1;
               pop      = 1'b1;
            end
            S_JMP: begin
               PCSrc   = 1'b1;
               PCWrite = 1'b1;
            end
            S_JZ: begin
               PCSrc = 1'b1;
               PCJZ  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state = rst ? 4'd0 : cur;

endmodule
